// File: rtl/temporizador_alarme.sv
// temporizador_alarme: alarm arm/disarm FSM with BCD countdown digits for two 7-segment decoders
//   clock, reset_n (async, active low); armar, desarmar, sensor: control inputs
//   dezena, unidade: BCD seconds remaining, 4'hF blanks; armado, sirene, estado: status
module temporizador_alarme #(
  parameter int DIV_TICK  = 50000000,
  parameter int T_SAIDA   = 30,
  parameter int T_ENTRADA = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       armar,
  input  logic       desarmar,
  input  logic       sensor,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic       armado,
  output logic       sirene,
  output logic [2:0] estado
);
  localparam int PW = $clog2(DIV_TICK);
  localparam logic [2:0] DESARMADO = 3'd0;
  localparam logic [2:0] SAIDA     = 3'd1;
  localparam logic [2:0] ARMADO    = 3'd2;
  localparam logic [2:0] ENTRADA   = 3'd3;
  localparam logic [2:0] DISPARADO = 3'd4;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0] st_q, st_d;
  logic [3:0] dez_q, dez_d, uni_q, uni_d, dez_dec, uni_dec;
  logic arm_q, sir_q, tick, ultimo;
  assign tick    = pre_q == PW'(DIV_TICK - 1);
  // count <= 01 also covers a stray 00 so the countdown can never underflow
  assign ultimo  = dez_q == 4'd0 && uni_q <= 4'd1;
  assign dez_dec = uni_q == 4'd0 ? dez_q - 4'd1 : dez_q;
  assign uni_dec = uni_q == 4'd0 ? 4'd9 : uni_q - 4'd1;
  always_comb begin
    st_d  = st_q;
    dez_d = 4'hF;
    uni_d = 4'hF;
    case (st_q)
      DESARMADO: if (armar) begin
        st_d  = SAIDA;
        dez_d = 4'(T_SAIDA / 10);
        uni_d = 4'(T_SAIDA % 10);
      end
      SAIDA, ENTRADA: begin
        dez_d = tick ? dez_dec : dez_q;
        uni_d = tick ? uni_dec : uni_q;
        if (tick && ultimo) begin
          st_d  = st_q == SAIDA ? ARMADO : DISPARADO;
          dez_d = st_q == SAIDA ? 4'hF : 4'd0;
          uni_d = st_q == SAIDA ? 4'hF : 4'd0;
        end
      end
      ARMADO: if (sensor) begin
        st_d  = ENTRADA;
        dez_d = 4'(T_ENTRADA / 10);
        uni_d = 4'(T_ENTRADA % 10);
      end
      DISPARADO: begin
        dez_d = 4'd0;
        uni_d = 4'd0;
      end
      default: st_d = DESARMADO;
    endcase
    if (desarmar) begin
      st_d  = DESARMADO;
      dez_d = 4'hF;
      uni_d = 4'hF;
    end
  end
  // restarting on every state change makes each dwell an exact multiple of DIV_TICK
  assign pre_d = (st_d != st_q || tick) ? '0 : pre_q + PW'(1);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q  <= DESARMADO;
      pre_q <= '0;
      dez_q <= 4'hF;
      uni_q <= 4'hF;
      arm_q <= 1'b0;
      sir_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      pre_q <= pre_d;
      dez_q <= dez_d;
      uni_q <= uni_d;
      arm_q <= st_d == ARMADO || st_d == ENTRADA;
      sir_q <= st_d == DISPARADO;
    end
  end
  assign estado  = st_q;
  assign dezena  = dez_q;
  assign unidade = uni_q;
  assign armado  = arm_q;
  assign sirene  = sir_q;
endmodule

// File: tb/tb_temporizador_alarme.sv
// tb_temporizador_alarme: directed scoreboard bench for temporizador_alarme
module tb_temporizador_alarme;
  localparam logic [2:0] DES = 3'd0, SAI = 3'd1, ARM = 3'd2, ENT = 3'd3, DIS = 3'd4;
  localparam logic [3:0] F = 4'hF;
  logic clock = 1'b0, reset_n = 1'b0, armar = 1'b0, desarmar = 1'b0, sensor = 1'b0;
  logic [3:0] dezena, unidade;
  logic armado, sirene;
  logic [2:0] estado;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  typedef struct {
    int cyc;
    string nm;
    logic [2:0] st;
    logic [3:0] dz, un;
    logic ar, si;
  } exp_t;
  exp_t q[$];
  temporizador_alarme #(.DIV_TICK(4), .T_SAIDA(12), .T_ENTRADA(3)) dut (
    .clock(clock), .reset_n(reset_n), .armar(armar), .desarmar(desarmar), .sensor(sensor),
    .dezena(dezena), .unidade(unidade), .armado(armado), .sirene(sirene), .estado(estado)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic exp_at(input int off, input string nm, input logic [2:0] st,
                        input logic [3:0] dz, input logic [3:0] un, input logic ar, input logic si);
    q.push_back('{cyc + off, nm, st, dz, un, ar, si});
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: entry for cycle %0d not compared (now %0d)", e.nm, e.cyc, cyc);
      end else if ({estado, dezena, unidade, armado, sirene} !== {e.st, e.dz, e.un, e.ar, e.si}) begin
        n_bad++;
        $display("FAIL %s @%0d: got st=%0d d=%h u=%h arm=%b sir=%b, want st=%0d d=%h u=%h arm=%b sir=%b",
                 e.nm, cyc, estado, dezena, unidade, armado, sirene, e.st, e.dz, e.un, e.ar, e.si);
      end
    end
  end
  initial begin
    step(1);
    exp_at(0, "reset", DES, F, F, 0, 0);
    exp_at(1, "idle", DES, F, F, 0, 0);
    reset_n = 1'b1;
    step(1);
    armar = 1'b1;
    exp_at(1, "arm_load", SAI, 4'd1, 4'd2, 0, 0);
    exp_at(5, "exit_11", SAI, 4'd1, 4'd1, 0, 0);
    exp_at(9, "exit_10", SAI, 4'd1, 4'd0, 0, 0);
    exp_at(13, "exit_borrow", SAI, 4'd0, 4'd9, 0, 0);
    exp_at(48, "exit_last", SAI, 4'd0, 4'd1, 0, 0);
    exp_at(49, "armed", ARM, F, F, 1, 0);
    step(1);
    armar = 1'b0;
    step(48);
    sensor = 1'b1;
    exp_at(1, "entry_load", ENT, 4'd0, 4'd3, 1, 0);
    exp_at(5, "entry_02", ENT, 4'd0, 4'd2, 1, 0);
    exp_at(9, "entry_01", ENT, 4'd0, 4'd1, 1, 0);
    exp_at(12, "entry_last", ENT, 4'd0, 4'd1, 1, 0);
    exp_at(13, "trigger", DIS, 4'd0, 4'd0, 0, 1);
    step(1);
    sensor = 1'b0;
    step(12);
    for (int i = 1; i <= 100; i += 9) exp_at(i, "siren_hold", DIS, 4'd0, 4'd0, 0, 1);
    step(100);
    desarmar = 1'b1;
    exp_at(1, "disarm_dis", DES, F, F, 0, 0);
    step(1);
    desarmar = 1'b0;
    armar = 1'b1;
    exp_at(1, "rearm_load", SAI, 4'd1, 4'd2, 0, 0);
    exp_at(4, "rearm_hold", SAI, 4'd1, 4'd2, 0, 0);
    exp_at(5, "rearm_first", SAI, 4'd1, 4'd1, 0, 0);
    step(1);
    armar = 1'b0;
    step(5);
    reset_n = 1'b0;
    exp_at(0, "rst_async", DES, F, F, 0, 0);
    exp_at(1, "rst_after", DES, F, F, 0, 0);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    step(1);
    armar = 1'b1;
    desarmar = 1'b1;
    exp_at(1, "arm_and_disarm", DES, F, F, 0, 0);
    exp_at(2, "arm_and_disarm2", DES, F, F, 0, 0);
    step(2);
    desarmar = 1'b0;
    armar = 1'b1;
    sensor = 1'b1;
    exp_at(1, "noisy_load", SAI, 4'd1, 4'd2, 0, 0);
    exp_at(13, "noisy_borrow", SAI, 4'd0, 4'd9, 0, 0);
    exp_at(48, "noisy_last", SAI, 4'd0, 4'd1, 0, 0);
    exp_at(49, "noisy_armed", ARM, F, F, 1, 0);
    exp_at(50, "noisy_entry", ENT, 4'd0, 4'd3, 1, 0);
    step(1);
    armar = 1'b0;
    step(10);
    armar = 1'b1;
    step(1);
    armar = 1'b0;
    step(36);
    armar = 1'b1;
    step(1);
    armar = 1'b0;
    step(1);
    sensor = 1'b0;
    exp_at(4, "prio_02", ENT, 4'd0, 4'd2, 1, 0);
    exp_at(8, "prio_01", ENT, 4'd0, 4'd1, 1, 0);
    exp_at(11, "prio_last", ENT, 4'd0, 4'd1, 1, 0);
    for (int i = 12; i <= 20; i++) exp_at(i, "prio_disarm", DES, F, F, 0, 0);
    step(11);
    desarmar = 1'b1;
    step(1);
    desarmar = 1'b0;
    step(8);
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries never compared", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
